// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the ce-gated pipeline controller: FSM state encoding.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ce_ctrl_if.sv
// Valid/ready handshake bundle for the delay chain: upstream word in, last-stage word out.
interface pipe_ce_ctrl_if;

   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   // master = the environment around the chain (source and sink)
   modport master (
      output in_valid,
      output out_ready,
      input  in_ready,
      input  out_valid
   );

   modport slave (
      input  in_valid,
      input  out_ready,
      output in_ready,
      output out_valid
   );

endinterface : pipe_ce_ctrl_if

// File: rtl/pipe_vld_track.sv
// Valid-bit shadow of the DEPTH-stage delay chain plus a saturating occupancy counter.
module pipe_vld_track #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             clear,
   input  logic             accept,
   input  logic             out_hs,
   output logic             vld_last,
   output logic [CNT_W-1:0] occ
);

   localparam logic [CNT_W-1:0] OCC_MAX = CNT_W'(DEPTH);

   logic [DEPTH-1:0] vld;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         vld <= '0;
         occ <= '0;
      end else begin
         if (ce) begin
            vld <= {vld[DEPTH-2:0], accept};
         end
         if (accept && !out_hs && occ != OCC_MAX) begin
            occ <= occ + 1'b1;
         end else if (out_hs && !accept && occ != '0) begin
            occ <= occ - 1'b1;
         end
      end
   end

   assign vld_last = vld[DEPTH-1];

endmodule : pipe_vld_track

// File: rtl/pipe_ce_ctrl.sv
// Clock-enable / handshake controller for a DEPTH-stage delay chain with flush.
// Optional stall statistics output enabled by defining PIPE_CE_CTRL_STATS_EN.
module pipe_ce_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   pipe_ce_ctrl_if.slave    bus,
   input  logic             flush,
   output logic             ce,
   output logic [CNT_W-1:0] occupancy,
   output logic             busy
`ifdef PIPE_CE_CTRL_STATS_EN
   ,
   output logic [31:0]      stall_cnt
`endif
);

   localparam int             FC_W    = $clog2(DEPTH);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(DEPTH - 1);

   state_t           state_q, state_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic             vld_last;
   logic [CNT_W-1:0] occ_raw;
   logic             in_flush;
   logic             accept;
   logic             out_hs;
   logic             clear;

   assign in_flush = (state_q == FLUSH);

   // Outputs are forced to their reset values while rst_n is low, not just after the edge.
   assign ce            = rst_n & (in_flush | bus.out_ready | ~vld_last);
   assign bus.in_ready  = ce & ~flush & ~in_flush;
   assign bus.out_valid = rst_n & vld_last & ~in_flush;
   assign busy          = rst_n & (state_q != IDLE);
   assign occupancy     = rst_n ? occ_raw : '0;

   assign accept = bus.in_valid & bus.in_ready;
   assign out_hs = bus.out_valid & bus.out_ready;
   assign clear  = rst_n & flush & ~in_flush;

   pipe_vld_track #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_vld_track (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .clear    (clear),
      .accept   (accept),
      .out_hs   (out_hs),
      .vld_last (vld_last),
      .occ      (occ_raw)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (state_q)
         IDLE: begin
            if (flush) begin
               state_d = FLUSH;
               fcnt_d  = FC_LAST;
            end else if (accept) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
               fcnt_d  = FC_LAST;
            end else if (occ_raw == CNT_W'(1) && out_hs && !accept) begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            // flush requests are ignored here; the countdown always runs to completion
            if (fcnt_q == '0) begin
               state_d = IDLE;
            end else begin
               fcnt_d = fcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            fcnt_d  = '0;
         end
      endcase
   end

`ifdef PIPE_CE_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (bus.out_valid && !bus.out_ready && stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   // Stall statistics are compiled out in this build.
`endif

endmodule : pipe_ce_ctrl

// File: doc/pipe_ce_ctrl.md
PIPE_CE_CTRL -- requirements
Module: pipe_ce_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of ce-gated register stages in the controlled delay chain (legal range 2..64).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH+1): occupancy counter width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream has a word for stage 0.
REQ-006 SHALL have port in_ready, output, 1 bit: the chain accepts a word this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit: the last stage holds a valid word.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream consumes the last-stage word.
REQ-009 SHALL have port ce, output, 1 bit: clock enable driven to every stage of the delay chain.
REQ-010 SHALL have port flush, input, 1 bit: single-cycle request to discard all in-flight words.
REQ-011 SHALL have port occupancy, output, CNT_W bits: count of valid words in the chain.
REQ-012 SHALL have port busy, output, 1 bit: high when the state is not IDLE.

Function
REQ-013 SHALL keep a DEPTH-bit valid vector vld mirroring the chain; out_valid = vld[DEPTH-1] & (state != FLUSH).
REQ-014 SHALL drive ce = out_ready | ~vld[DEPTH-1] in IDLE/RUN, forced to 1 in FLUSH, and 0 while rst_n is low.
REQ-015 SHALL drive in_ready = ce & ~flush & (state != FLUSH), combinationally.
REQ-016 SHALL shift vld on ce: vld <= {vld[DEPTH-2:0], in_valid & in_ready}; bubbles propagate and are not collapsed.
REQ-017 SHALL give a fixed latency of exactly DEPTH ce-active cycles from input acceptance to out_valid.
REQ-018 SHALL update occupancy: +1 on input accept only, -1 on output handshake only, unchanged when both or neither occur; it never exceeds DEPTH and never wraps below 0.
REQ-019 SHALL implement states IDLE (occupancy 0), RUN (occupancy > 0) and FLUSH.
REQ-020 SHALL transition IDLE->RUN on input accept, and RUN->IDLE when the occupancy reaches 0.
REQ-021 SHALL transition IDLE/RUN->FLUSH on flush=1; flush has priority over every other transition.
REQ-022 SHALL complete an output handshake that occurs in the same cycle as flush; an input offered in that cycle is refused (in_ready=0).
REQ-023 SHALL, on entry to FLUSH, clear vld and occupancy to 0, hold FLUSH for DEPTH cycles with ce=1 via a down-counter, then go to IDLE.
REQ-024 SHALL ignore flush while in FLUSH (the counter is not restarted).

Reset
REQ-025 SHALL, while rst_n is low at a clock edge: state=IDLE, vld=0, occupancy=0, flush counter=0.
REQ-026 SHALL hold these output values during reset: ce=0, in_ready=0, out_valid=0, busy=0.
REQ-027 SHALL drop all in-flight words when reset is asserted mid-operation; the first cycle after release has ce=1 and in_ready=1.

Configuration
REQ-028 SHALL, with macro PIPE_CE_CTRL_STATS_EN defined, add output stall_cnt (32 bits), which counts cycles with out_valid & ~out_ready, saturates at 2^32-1, and is cleared by reset only.
REQ-029 SHALL, without PIPE_CE_CTRL_STATS_EN, omit the port and counter entirely.

Structure
REQ-030 SHALL take the state enum typedef (IDLE/RUN/FLUSH) from the shared package pipe_ctrl_pkg.
REQ-031 SHALL place the vld shift register and occupancy counter in sub-module pipe_vld_track; the FSM, ce/ready logic and stats stay in the top level.

Verification
REQ-032 SHALL cover: DEPTH=4, out_ready=1, one word in at cycle 0 -> out_valid at cycle 4; occupancy 1 for cycles 1..4.
REQ-033 SHALL cover: continuous in_valid, out_ready held 0 -> after 4 accepts, ce=0, in_ready=0, occupancy=4; out_ready=1 -> one word out per cycle.
REQ-034 SHALL cover: occupancy=3 with simultaneous input accept and output handshake -> occupancy stays 3.
REQ-035 SHALL cover: flush while occupancy=3 and out handshake active -> that handshake counts; next cycle occupancy=0, busy=1, in_ready=0 for 4 cycles, then IDLE.
REQ-036 SHALL cover: rst_n low for 1 cycle mid-stream -> all outputs at reset values; next cycle ce=1, in_ready=1, occupancy=0.
REQ-037 SHALL cover, with STATS_EN: out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10.
